mem_cmd_sequencer: RTL and testbench

Executes the memory-class commands (opcodes 0x07–0x0A) produced by the SPI instruction/data buffer. It sits directly downstream of that buffer, consuming its `instruction`, `data` and `valid_buffer_for_mem` outputs. It drives a single-port, word-wide memory request/ready interface and returns one result word per command. Each command is run to completion before the next one is accepted. Commands that arrive while the block is busy are dropped and counted.

---
 rtl/mem_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_sequencer.sv
// Memory command sequencer: WRITE/READ/FILL/CHECKSUM over a req/ready port.
// Optional wait watchdog enabled by defining MEM_CMD_TIMEOUT_EN.
module mem_cmd_sequencer #(
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              sysClk,
    input  logic              reset,
    input  logic [7:0]        instruction,
    input  logic [63:0]       data,
    input  logic              valid_buffer_for_mem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              result_valid,
    output logic [7:0]        result_opcode,
    output logic [31:0]       result_data,
    output logic              cmd_error,
    output logic [7:0]        drop_count
);

    localparam logic [7:0] OP_WRITE = 8'h07;
    localparam logic [7:0] OP_READ  = 8'h08;
    localparam logic [7:0] OP_FILL  = 8'h09;
    localparam logic [7:0] OP_CSUM  = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q;
    logic [16:0] rem_q;
    logic [16:0] done_q;
    logic [31:0] sum_q;

    logic        accept;
    logic        rd_beat;
    logic        tmo_hit;
    logic [15:0] cnt_in;
    logic        is_bulk;
    logic [31:0] res_data_d;
    logic        res_err_d;
    logic [7:0]  res_op_d;
    logic        unused_ok;

    assign accept  = mem_ready & (mem_we | mem_re);
    assign rd_beat = (state_q == S_RD_WAIT) & mem_rvalid;
    assign cnt_in  = data[31:16];
    assign is_bulk = (instruction == OP_FILL) | (instruction == OP_CSUM);
    assign busy    = (state_q != S_IDLE);

    assign unused_ok = ^{data[63:32+ADDR_W], TIMEOUT_CYCLES != 0};

`ifdef MEM_CMD_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        waiting;
    logic        progress;

    assign waiting  = (state_q == S_WR) | (state_q == S_RD_REQ) |
                      (state_q == S_RD_WAIT);
    assign progress = accept | mem_rvalid;
    assign tmo_hit  = waiting & ~progress &
                      (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sysClk) begin
        if (reset || !waiting || progress || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        res_data_d = '0;
        res_err_d  = 1'b0;
        res_op_d   = op_q;
        unique case (state_q)
            S_IDLE: begin
                res_op_d = instruction;
                if (valid_buffer_for_mem) begin
                    case (instruction)
                        OP_WRITE: state_d = S_WR;
                        OP_READ:  state_d = S_RD_REQ;
                        OP_FILL:  state_d = (cnt_in == '0) ? S_DONE : S_WR;
                        OP_CSUM:  state_d = (cnt_in == '0) ? S_DONE : S_RD_REQ;
                        default: begin
                            state_d   = S_DONE;
                            res_err_d = 1'b1;
                        end
                    endcase
                end
            end
            S_WR: begin
                if (tmo_hit) begin
                    state_d   = S_DONE;
                    res_err_d = 1'b1;
                    if (op_q == OP_FILL) res_data_d = {15'd0, done_q};
                end else if (accept && rem_q == 17'd1) begin
                    state_d    = S_DONE;
                    res_data_d = (op_q == OP_FILL) ?
                                 {15'd0, done_q + 17'd1} : 32'd1;
                end
            end
            S_RD_REQ: begin
                if (tmo_hit) begin
                    state_d    = S_DONE;
                    res_err_d  = 1'b1;
                    res_data_d = sum_q;
                end else if (accept) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (tmo_hit) begin
                    state_d    = S_DONE;
                    res_err_d  = 1'b1;
                    res_data_d = sum_q;
                end else if (mem_rvalid) begin
                    res_data_d = sum_q + mem_rdata;
                    state_d    = (rem_q == 17'd1) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            rem_q         <= '0;
            done_q        <= '0;
            sum_q         <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
            result_valid  <= 1'b0;
            result_opcode <= '0;
            result_data   <= '0;
            cmd_error     <= 1'b0;
            drop_count    <= '0;
        end else begin
            state_q      <= state_d;
            mem_we       <= (state_d == S_WR);
            mem_re       <= (state_d == S_RD_REQ);
            result_valid <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                result_data   <= res_data_d;
                cmd_error     <= res_err_d;
                result_opcode <= res_op_d;
            end
            if (valid_buffer_for_mem && busy && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            if (state_q == S_IDLE && valid_buffer_for_mem) begin
                op_q      <= instruction;
                mem_addr  <= data[32 +: ADDR_W];
                mem_wdata <= (instruction == OP_FILL) ?
                             {data[15:0], data[15:0]} : data[31:0];
                rem_q     <= is_bulk ? {1'b0, cnt_in} : 17'd1;
                done_q    <= '0;
                sum_q     <= '0;
            end
            // Address advances on each accepted request; counters track words.
            if (accept) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            if (accept && state_q == S_WR) begin
                rem_q  <= rem_q - 17'd1;
                done_q <= done_q + 17'd1;
            end
            if (rd_beat) begin
                sum_q  <= sum_q + mem_rdata;
                rem_q  <= rem_q - 17'd1;
                done_q <= done_q + 17'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Directed + randomized bench for mem_cmd_sequencer with a memory responder
// and a reference model derived from the command rules.
module tb_mem_cmd_sequencer;

    localparam int AW   = 18;
    localparam int MASK = (1 << AW) - 1;

    typedef struct packed {
        logic [7:0]  op;
        logic        err;
        logic [31:0] d;
    } res_t;

    logic          sysClk = 1'b0;
    logic          reset;
    logic [7:0]    instruction;
    logic [63:0]   data;
    logic          valid_buffer_for_mem;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic          busy;
    logic          result_valid;
    logic [7:0]    result_opcode;
    logic [31:0]   result_data;
    logic          cmd_error;
    logic [7:0]    drop_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ready_mode = 0;
    int          lat = 1;
    bit          inj_rvalid = 0;
    logic [31:0] mem [int];
    int          wr_a [$];
    logic [31:0] wr_d [$];
    int          rd_a [$];
    res_t        res_q [$];
    int          ov_cnt = 0;
    int          res_pulses = 0;
    bit          rd_pending = 0;
    int          rd_timer = 0;
    logic [31:0] rd_word = '0;

    mem_cmd_sequencer #(
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .sysClk(sysClk),
        .reset(reset),
        .instruction(instruction),
        .data(data),
        .valid_buffer_for_mem(valid_buffer_for_mem),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .busy(busy),
        .result_valid(result_valid),
        .result_opcode(result_opcode),
        .result_data(result_data),
        .cmd_error(cmd_error),
        .drop_count(drop_count)
    );

    always #5 sysClk = ~sysClk;

    function automatic logic [31:0] mval(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'(a) * 32'h9E3779B1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysClk);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [63:0] d);
        instruction          = op;
        data                 = d;
        valid_buffer_for_mem = 1'b1;
        step();
        valid_buffer_for_mem = 1'b0;
    endtask

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        rd_a.delete();
        res_q.delete();
    endtask

    task automatic wait_res(input string tag, input int budget,
                            output res_t r);
        int i = 0;
        while (res_q.size() == 0 && i < budget) begin
            step();
            i++;
        end
        chk({tag, "_done"}, 64'(res_q.size() != 0), 64'd1);
        if (res_q.size() != 0) r = res_q.pop_front();
        else r = '0;
    endtask

    // Memory responder: logs accepts, returns reads after 'lat' cycles.
    initial begin
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge sysClk);
            if (result_valid) begin
                res_q.push_back({result_opcode, cmd_error, result_data});
                res_pulses++;
            end
            if (mem_we && mem_ready) begin
                wr_a.push_back(int'(mem_addr));
                wr_d.push_back(mem_wdata);
                mem[int'(mem_addr)] = mem_wdata;
            end
            if (mem_re && mem_ready) begin
                if (rd_pending) ov_cnt++;
                rd_pending = 1;
                rd_timer   = lat;
                rd_word    = mval(int'(mem_addr));
                rd_a.push_back(int'(mem_addr));
            end
            @(posedge sysClk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (rd_pending) begin
                rd_timer--;
                if (rd_timer == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_word;
                    rd_pending = 0;
                end
            end
            if (inj_rvalid) begin
                mem_rvalid = 1'b1;
                inj_rvalid = 0;
            end
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ~mem_ready;
                2:       mem_ready = 1'($urandom);
                default: mem_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        r;
        int          p;
        int          cyc;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [15:0] cnt;
        logic [15:0] pat;
        logic [63:0] d;
        int          a0;
        int          ea [$];
        logic [31:0] ed [$];
        int          er [$];
        logic [31:0] exp_d;
        logic        exp_err;

        reset                = 1'b1;
        valid_buffer_for_mem = 1'b0;
        instruction          = '0;
        data                 = '0;
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_re", 64'(mem_re), 64'd0);
        chk("rst_rv", 64'(result_valid), 64'd0);
        chk("rst_err", 64'(cmd_error), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rdata", 64'(result_data), 64'd0);
        chk("rst_rop", 64'(result_opcode), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b0;
        step();

        // WRITE with exact cycle timing
        clear_logs();
        send(8'h07, 64'h00000010_DEADBEEF);
        chk("wr_we_c1", 64'(mem_we), 64'd1);
        chk("wr_addr", 64'(mem_addr), 64'h10);
        chk("wr_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("wr_rv_c1", 64'(result_valid), 64'd0);
        step();
        chk("wr_we_c2", 64'(mem_we), 64'd0);
        chk("wr_rv_c2", 64'(result_valid), 64'd1);
        chk("wr_res", 64'(result_data), 64'd1);
        chk("wr_op", 64'(result_opcode), 64'h07);
        chk("wr_err", 64'(cmd_error), 64'd0);
        step();
        chk("wr_rv_c3", 64'(result_valid), 64'd0);
        chk("wr_busy_c3", 64'(busy), 64'd0);
        chk("wr_count", 64'(wr_a.size()), 64'd1);
        chk("wr_held_res", 64'(result_data), 64'd1);

        // FILL across address wrap with toggling ready
        clear_logs();
        ready_mode = 1;
        send(8'h09, {32'h0003FFFE, 16'd4, 16'hA5A5});
        wait_res("fill", 100, r);
        chk("fill_res", 64'(r.d), 64'd4);
        chk("fill_err", 64'(r.err), 64'd0);
        chk("fill_n", 64'(wr_a.size()), 64'd4);
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
            chk("fill_addr", 64'(wr_a[i]), 64'((32'h3FFFE + i) & MASK));
            chk("fill_data", 64'(wr_d[i]), 64'hA5A5A5A5);
        end

        // CHECKSUM with rvalid latency 3
        clear_logs();
        ready_mode = 0;
        lat        = 3;
        mem[100]   = 32'hFFFFFFFF;
        mem[101]   = 32'd2;
        mem[102]   = 32'd5;
        send(8'h0A, {32'd100, 16'd3, 16'h0});
        wait_res("csum", 100, r);
        chk("csum_res", 64'(r.d), 64'd6);
        chk("csum_reads", 64'(rd_a.size()), 64'd3);
        chk("csum_outst", 64'(ov_cnt), 64'd0);

        // READ with a dropped command during RD_WAIT
        clear_logs();
        lat          = 5;
        mem[32'h2222] = 32'hCAFEF00D;
        send(8'h08, {32'h2222, 32'h0});
        for (int i = 0; i < 20 && !rd_pending; i++) step();
        chk("rd_issued", 64'(rd_pending), 64'd1);
        send(8'h07, {32'h55, 32'h12345678});
        wait_res("read", 100, r);
        chk("read_res", 64'(r.d), 64'hCAFEF00D);
        chk("read_op", 64'(r.op), 64'h08);
        chk("drop_one", 64'(drop_count), 64'd1);
        chk("drop_nowr", 64'(wr_a.size()), 64'd0);

        // Saturating drop counter during a long FILL
        clear_logs();
        lat = 1;
        send(8'h09, {32'h100, 16'd400, 16'h1234});
        for (int i = 0; i < 300; i++) begin
            instruction          = 8'($urandom);
            valid_buffer_for_mem = 1'b1;
            step();
        end
        valid_buffer_for_mem = 1'b0;
        chk("drop_sat", 64'(drop_count), 64'd255);
        wait_res("bigfill", 600, r);
        chk("bigfill_res", 64'(r.d), 64'd400);
        chk("bigfill_n", 64'(wr_a.size()), 64'd400);
        if (wr_a.size() == 400) begin
            chk("bigfill_last", 64'(wr_a[399]), 64'(32'h100 + 399));
        end

        // Unknown opcode and zero-count bulk commands
        clear_logs();
        send(8'h55, 64'h0123456789ABCDEF);
        chk("unk_rv", 64'(result_valid), 64'd1);
        chk("unk_err", 64'(cmd_error), 64'd1);
        chk("unk_res", 64'(result_data), 64'd0);
        chk("unk_op", 64'(result_opcode), 64'h55);
        step();
        chk("unk_busy", 64'(busy), 64'd0);
        send(8'h0A, {32'h5, 16'd0, 16'h0});
        chk("c0_rv", 64'(result_valid), 64'd1);
        chk("c0_err", 64'(cmd_error), 64'd0);
        chk("c0_res", 64'(result_data), 64'd0);
        step();
        send(8'h09, {32'h5, 16'd0, 16'hFFFF});
        chk("f0_rv", 64'(result_valid), 64'd1);
        chk("f0_res", 64'(result_data), 64'd0);
        step();
        chk("c0_mem", 64'(rd_a.size() + wr_a.size()), 64'd0);

        // Reset in the middle of a FILL
        clear_logs();
        send(8'h09, {32'h200, 16'd100, 16'hBEEF});
        repeat (9) step();
        reset = 1'b1;
        step();
        chk("rstm_we", 64'(mem_we), 64'd0);
        chk("rstm_busy", 64'(busy), 64'd0);
        chk("rstm_rv", 64'(result_valid), 64'd0);
        chk("rstm_words", 64'(wr_a.size()), 64'd10);
        reset = 1'b0;
        p     = res_pulses;
        inj_rvalid = 1;
        repeat (5) step();
        chk("rstm_late_rv", 64'(res_pulses - p), 64'd0);
        chk("rstm_idle", 64'(busy), 64'd0);

        // Randomized commands against the reference model
        for (int k = 0; k < 40; k++) begin
            ready_mode = $urandom_range(0, 2);
            lat        = $urandom_range(1, 4);
            case ($urandom_range(0, 4))
                0: op = 8'h07;
                1: op = 8'h08;
                2: op = 8'h09;
                3: op = 8'h0A;
                default: op = 8'($urandom_range(11, 255));
            endcase
            addr = $urandom;
            cnt  = 16'($urandom_range(0, 6));
            pat  = 16'($urandom);
            d    = (op == 8'h09 || op == 8'h0A) ?
                   {addr, cnt, pat} : {addr, 32'($urandom)};
            a0   = int'(addr) & MASK;
            ea.delete();
            ed.delete();
            er.delete();
            exp_d   = '0;
            exp_err = 1'b0;
            case (op)
                8'h07: begin
                    ea.push_back(a0);
                    ed.push_back(d[31:0]);
                    exp_d = 1;
                end
                8'h08: begin
                    er.push_back(a0);
                    exp_d = mval(a0);
                end
                8'h09: begin
                    for (int i = 0; i < int'(cnt); i++) begin
                        ea.push_back((a0 + i) & MASK);
                        ed.push_back({pat, pat});
                    end
                    exp_d = 32'(cnt);
                end
                8'h0A: begin
                    for (int i = 0; i < int'(cnt); i++) begin
                        er.push_back((a0 + i) & MASK);
                        exp_d += mval((a0 + i) & MASK);
                    end
                end
                default: exp_err = 1'b1;
            endcase
            clear_logs();
            send(op, d);
            wait_res("rnd", 300, r);
            chk("rnd_res", 64'(r.d), 64'(exp_d));
            chk("rnd_err", 64'(r.err), 64'(exp_err));
            chk("rnd_op", 64'(r.op), 64'(op));
            chk("rnd_nwr", 64'(wr_a.size()), 64'(ea.size()));
            chk("rnd_nrd", 64'(rd_a.size()), 64'(er.size()));
            for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
                chk("rnd_wa", 64'(wr_a[i]), 64'(ea[i]));
                chk("rnd_wd", 64'(wr_d[i]), 64'(ed[i]));
            end
            for (int i = 0; i < er.size() && i < rd_a.size(); i++) begin
                chk("rnd_ra", 64'(rd_a[i]), 64'(er[i]));
            end
        end
        chk("rnd_outst", 64'(ov_cnt), 64'd0);

        // Memory never ready
        clear_logs();
        ready_mode = 3;
        send(8'h08, {32'h77, 32'h0});
`ifdef MEM_CMD_TIMEOUT_EN
        cyc = 1;
        while (!result_valid && cyc < 100) begin
            step();
            cyc++;
        end
        chk("tmo_cycle", 64'(cyc), 64'd17);
        chk("tmo_err", 64'(cmd_error), 64'd1);
        chk("tmo_res", 64'(result_data), 64'd0);
        step();
        chk("tmo_idle", 64'(busy), 64'd0);
`else
        cyc = 1;
        repeat (999) begin
            step();
            cyc++;
        end
        chk("hang_busy", 64'(busy), 64'd1);
        chk("hang_re", 64'(mem_re), 64'd1);
        chk("hang_nores", 64'(res_q.size()), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("hang_rst", 64'(busy), 64'd0);
`endif
        ready_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
